// File: rtl/nibble_serial_tx_if.sv
// Word-load handshake and serial line of the nibble transmitter.
// The upstream register drives D/en; the transmitter drives the rest.
interface nibble_serial_tx_if;
    logic [3:0] D;
    logic       en;
    logic       ready;
    logic       TXD;
    logic       busy;
    logic       done;

    modport master (output D, en, input ready, TXD, busy, done);
    modport slave  (input D, en, output ready, TXD, busy, done);
endinterface

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter for 4-bit words: start, 4 data bits LSB first,
// optional even parity, stop. A one-word hold buffer allows gapless frames.
//
// state    | meaning
// S_IDLE   | line high, waiting for a word
// S_START  | start bit (TXD=0)
// S_DATA   | data bits, sh[0] on the line, bit_cnt selects bit 0..3
// S_PARITY | even-parity bit over the 4 data bits
// S_STOP   | stop bit (TXD=1); next word or idle at its end
module nibble_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    nibble_serial_tx_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Baud timer counts down; the bit ends when it reaches zero.
    localparam logic [7:0] BAUD_RELOAD = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [3:0] sh_q, sh_d;
    logic       par_q, par_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] baud_cnt_q, baud_cnt_d;
    logic [3:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       bit_end;
    logic       accept;

    assign bit_end = (baud_cnt_q == 8'd0);
    assign accept  = bus.en && !full_q;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        hold_d     = hold_q;
        full_d     = full_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d       = bus.D;
                    par_d      = ^bus.D;
                    bit_cnt_d  = 2'd0;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = BAUD_RELOAD;
                    bit_cnt_d  = 2'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == 2'd3) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 2'd1;
                        sh_d      = {1'b0, sh_q[3:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 8'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q - 8'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d    = 1'b1;
                    bit_cnt_d = 2'd0;
                    // A held word has priority over a fresh load on the same edge.
                    if (full_q) begin
                        sh_d       = hold_q;
                        par_d      = ^hold_q;
                        full_d     = 1'b0;
                        baud_cnt_d = BAUD_RELOAD;
                        state_d    = S_START;
                    end else if (bus.en) begin
                        sh_d       = bus.D;
                        par_d      = ^bus.D;
                        baud_cnt_d = BAUD_RELOAD;
                        state_d    = S_START;
                    end else begin
                        baud_cnt_d = 8'd0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept && (state_q != S_IDLE) && !((state_q == S_STOP) && bit_end)) begin
            hold_d = bus.D;
            full_d = 1'b1;
        end
    end

    always_comb begin
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = sh_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            sh_q       <= 4'd0;
            par_q      <= 1'b0;
            bit_cnt_q  <= 2'd0;
            baud_cnt_q <= 8'd0;
            hold_q     <= 4'd0;
            full_q     <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready = !full_q;
    assign bus.TXD   = txd_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: one N=4/parity instance and one
// N=1/no-parity instance, checked with immediate assertions.
module tb_nibble_serial_tx;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    nibble_serial_tx_if ifa ();
    nibble_serial_tx_if ifb ();

    nibble_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_a (
        .CLK (CLK),
        .RST (RST),
        .bus (ifa)
    );

    nibble_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_b (
        .CLK (CLK),
        .RST (RST),
        .bus (ifb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected line levels per bit slot, slot 0 (start) in bit 0.
    logic [6:0] exp_single;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    logic [5:0] exp_fast;

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_single = 7'b1010100;   // D=1010, parity 0
        exp_a      = 7'b1101110;   // D=0111, parity 1
        exp_b      = 7'b1100010;   // D=0001, parity 1
        exp_fast   = 6'b111000;    // D=1100, no parity
        RST    = 1'b0;
        ifa.D  = 4'd0;
        ifa.en = 1'b0;
        ifb.D  = 4'd0;
        ifb.en = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_txd",   0, ifa.TXD,   1'b1);
        chk("rst_ready", 0, ifa.ready, 1'b1);
        chk("rst_busy",  0, ifa.busy,  1'b0);
        chk("rst_done",  0, ifa.done,  1'b0);
        chk("rst_txd_b", 0, ifb.TXD,   1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rel_txd",  0, ifa.TXD,  1'b1);
        chk("rel_busy", 0, ifa.busy, 1'b0);

        // Single frame, N=4, parity on
        ifa.D  = 4'b1010;
        ifa.en = 1'b1;
        for (int k = 0; k <= 29; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) begin
                ifa.en = 1'b0;
                ifa.D  = 4'b0101;
            end
            if (k < 28) chk("single_txd", k, ifa.TXD, exp_single[k / 4]);
            else        chk("single_idle_txd", k, ifa.TXD, 1'b1);
            chk("single_done", k, ifa.done, (k == 28));
            chk("single_busy", k, ifa.busy, (k < 28));
        end

        // Back-to-back with a held word; en with D=F while full must be ignored
        ifa.D  = 4'b0111;
        ifa.en = 1'b1;
        for (int k = 0; k <= 57; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) ifa.en = 1'b0;
            if (k == 5) begin
                ifa.D  = 4'b0001;
                ifa.en = 1'b1;
            end
            if (k == 6) begin
                chk("b2b_ready_low", k, ifa.ready, 1'b0);
                ifa.D  = 4'hF;
                ifa.en = 1'b1;
            end
            if (k == 10) begin
                ifa.en = 1'b0;
                ifa.D  = 4'h0;
            end
            if (k == 27) chk("b2b_ready_held", k, ifa.ready, 1'b0);
            if (k == 28) chk("b2b_ready_deq", k, ifa.ready, 1'b1);
            if (k < 28)      chk("b2b_txd_a", k, ifa.TXD, exp_a[k / 4]);
            else if (k < 56) chk("b2b_txd_b", k, ifa.TXD, exp_b[(k - 28) / 4]);
            else             chk("b2b_idle_txd", k, ifa.TXD, 1'b1);
            chk("b2b_done", k, ifa.done, (k == 28) || (k == 56));
            chk("b2b_busy", k, ifa.busy, (k < 56));
        end

        // No parity, one cycle per bit
        ifb.D  = 4'b1100;
        ifb.en = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) ifb.en = 1'b0;
            if (k < 6) chk("fast_txd", k, ifb.TXD, exp_fast[k]);
            else       chk("fast_idle_txd", k, ifb.TXD, 1'b1);
            chk("fast_done", k, ifb.done, (k == 6));
            chk("fast_busy", k, ifb.busy, (k < 6));
        end

        // Reset during data bit 2 (edges 12..15)
        ifa.D  = 4'b1010;
        ifa.en = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) ifa.en = 1'b0;
        end
        chk("mid_txd_before", 13, ifa.TXD, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_txd_async", 0, ifa.TXD,   1'b1);
        chk("mid_busy",      0, ifa.busy,  1'b0);
        chk("mid_ready",     0, ifa.ready, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            chk("post_rst_done", k, ifa.done, 1'b0);
            chk("post_rst_busy", k, ifa.busy, 1'b0);
            chk("post_rst_txd",  k, ifa.TXD,  1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
